npc_unit: RTL
=============

# npc_unit

Next-PC selection stage for the Forth processor; drives the `nPC` input of the program-counter register each cycle. It decodes the control-flow operation of the current instruction and computes the fetch address for the next cycle. It owns the hardware return stack used by CALL/RET and by the Forth `>R` / `R>` words.

## Interface
- DEPTH, 16: return-stack entries; power of two, 2..256.
- AW, 16: address/data width; matches the PC width.

- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- PC  in  AW  current PC, taken from the PC register output.
- Op  in  3  operation: 0 NEXT, 1 JMP, 2 JZ, 3 CALL, 4 RET, 5 HOLD, 6 PUSHR, 7 POPR.
- Target  in  AW  jump/call target, or the data word for PUSHR.
- Zero  in  1  data-stack TOS == 0; used only by JZ.
- Stall  in  1  pipeline stall.
- nPC  out  AW  next PC (combinational).
- RetTop  out  AW  top return-stack entry; 0 when the stack is empty.
- Depth  out  log2(DEPTH)+1  number of valid entries.
- Overflow  out  1  sticky; set by a push while full.
- Underflow  out  1  sticky; set by a pop while empty.

## Operation
- State: storage array of DEPTH×AW, stack pointer `sp` (= Depth), and the two sticky flags. No other registers.
- `PC+1` is computed modulo 2^AW, so 0xFFFF+1 = 0x0000.
- nPC per Op, when not stalled and not in reset:
  - NEXT: PC+1.
  - JMP: Target.
  - JZ: Target if Zero=1, else PC+1.
  - CALL: Target; pushes PC+1.
  - RET: RetTop; pops.
  - HOLD: PC.
  - PUSHR: PC+1; pushes Target.
  - POPR: PC+1; pops. The caller samples RetTop in the same cycle, before the edge.
- Push while Depth == DEPTH: no write, sp unchanged, Overflow←1. nPC is still computed normally (CALL still jumps to Target).
- Pop while Depth == 0: sp unchanged, Underflow←1. RET then gives nPC = 0, i.e. a restart vector. POPR gives nPC = PC+1.
- Stall=1: nPC = PC, no stack or flag change, Op ignored.
- Rst=1 (overrides Stall and Op):
  - nPC = 0 combinationally.
  - At the edge: sp←0, Overflow←0, Underflow←0.
  - Storage contents are don't-care.
- Sticky flags clear only on Rst.
- No simultaneous push and pop: each op does at most one stack action.

## Timing
- nPC, RetTop: combinational from PC, Op, Target, Zero, Stall, Rst and the current stack state; zero latency. The PC register captures nPC at the next edge.
- Stack/flag updates take effect at the rising edge ending the cycle in which the op is presented. Depth and RetTop reflect the update in the following cycle.
- Back-to-back ops are allowed every cycle; no bubbles are required. A CALL followed immediately by a RET returns to the call's PC+1.
- Reset values after a Rst edge:
  - Depth = 0, RetTop = 0, Overflow = 0, Underflow = 0.
  - nPC = PC+1, assuming Op=NEXT and Stall=0.
- Reset mid-operation: a push or pop presented in the same cycle as Rst is discarded.
- Critical path: stack read → RET mux → nPC. The array is read asynchronously (distributed RAM or registers).

## Test plan
- Reset, then NEXT with PC=0x0010 → nPC=0x0011, Depth=0, all flags 0. With PC=0xFFFF → nPC=0x0000.
- JZ, Target=0x0200, PC=0x0040: Zero=1 → nPC=0x0200; Zero=0 → nPC=0x0041.
- Nested calls and returns:
  - CALL 0x0100 @PC=0x0005, then CALL 0x0300 @PC=0x0102 → Depth=2, RetTop=0x0103.
  - RET @PC=0x0305 → nPC=0x0103.
  - RET @PC=0x0110 → nPC=0x0006, Depth=0.
- Return-stack data words:
  - PUSHR 0xBEEF → RetTop=0xBEEF next cycle.
  - POPR → RetTop=0xBEEF during the POPR cycle, nPC=PC+1, Depth back to 0.
- Overflow/underflow (DEPTH=16):
  - 17 CALLs → Depth=16, Overflow=1, 17th nPC=Target.
  - Reset, then RET on empty → nPC=0, Underflow=1.
  - Stays 1 through 5 NEXT cycles; cleared by Rst.
- Stall and reset priority:
  - Stall=1 with Op=CALL, PC=0x0020 → nPC=0x0020, Depth unchanged.
  - Rst=1 with Op=CALL → nPC=0, Depth=0 after the edge.

Source files
------------

// File: rtl/npc_unit.sv
// Next-PC selection for the Forth core: decodes the control-flow op, computes the
// fetch address for the next cycle and owns the hardware return stack.
module npc_unit #(
  parameter int DEPTH = 16,
  parameter int AW    = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [AW-1:0]            PC,
  input  logic [2:0]               Op,
  input  logic [AW-1:0]            Target,
  input  logic                     Zero,
  input  logic                     Stall,
  output logic [AW-1:0]            nPC,
  output logic [AW-1:0]            RetTop,
  output logic [$clog2(DEPTH):0]   Depth,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int SW = IW + 1;

  typedef enum logic [2:0] {
    OP_NEXT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_JZ    = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_HOLD  = 3'd5,
    OP_PUSHR = 3'd6,
    OP_POPR  = 3'd7
  } op_e;

  logic [AW-1:0] mem [DEPTH];
  logic [SW-1:0] sp;
  logic [IW-1:0] top_idx;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] push_data;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  op_e           op;

  assign op      = op_e'(Op);
  assign pc_inc  = PC + 1'b1;
  assign full    = (sp == SW'(DEPTH));
  assign empty   = (sp == '0);
  // Low bits wrap correctly when sp == DEPTH (index 0 - 1 = DEPTH-1).
  assign top_idx = sp[IW-1:0] - 1'b1;
  assign RetTop  = empty ? '0 : mem[top_idx];
  assign Depth   = sp;

  always_comb begin
    nPC       = pc_inc;
    push_data = pc_inc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    if (Rst) begin
      nPC = '0;
    end else if (Stall) begin
      nPC = PC;
    end else begin
      case (op)
        OP_NEXT:  nPC = pc_inc;
        OP_JMP:   nPC = Target;
        OP_JZ:    nPC = Zero ? Target : pc_inc;
        OP_CALL: begin
          nPC     = Target;
          do_push = 1'b1;
        end
        OP_RET: begin
          nPC    = RetTop;
          do_pop = 1'b1;
        end
        OP_HOLD:  nPC = PC;
        OP_PUSHR: begin
          nPC       = pc_inc;
          push_data = Target;
          do_push   = 1'b1;
        end
        OP_POPR: begin
          nPC    = pc_inc;
          do_pop = 1'b1;
        end
        default:  nPC = pc_inc;
      endcase
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge Clk) begin
    if (do_push && !full) begin
      mem[sp[IW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sp        <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (do_push) begin
        if (full) Overflow <= 1'b1;
        else      sp <= sp + 1'b1;
      end
      if (do_pop) begin
        if (empty) Underflow <= 1'b1;
        else       sp <= sp - 1'b1;
      end
    end
  end

endmodule
